alu_lcd_writer: RTL and testbench
=================================

# alu_lcd_writer

Sequential display back-end for the 4-bit ALU.
- Captures one ALU result (8-bit value plus the 4-bit operation select) on a start strobe.
- Renders it as ASCII on an HD44780-compatible character LCD in 8-bit write-only mode, e.g. `MUL=225`.
- Sits between the ALU result bus and the LCD pins, and owns LCD power-up initialisation and all bus timing.

## Interface
- `E_PULSE_CYC`, default 25: cycles `lcd_e` is held high per byte.
- `CMD_WAIT_CYC`, default 2500: settle cycles after a normal command or character.
- `CLR_WAIT_CYC`, default 100000: settle cycles after the clear command (0x01).
- `INIT_WAIT_CYC`, default 750000: power-up delay before the first command.
- `clk`, input, 1: single clock, all logic on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: one-cycle request to display the current `sel`/`result`.
- `sel`, input, 4: ALU operation code.
- `result`, input, 8: ALU result.
- `busy`, output, 1: high while initialising or displaying; `start` is ignored while high.
- `done`, output, 1: one-cycle pulse when a display sequence completes.
- `lcd_rs`, output, 1: 0 = command, 1 = data.
- `lcd_rw`, output, 1: tied 0 (write only).
- `lcd_e`, output, 1: LCD enable strobe.
- `lcd_data`, output, 8: LCD data bus.

## Operation
- **Reset values:** `busy`=1, `done`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_e`=0, `lcd_data`=0x00. Reset restarts the power-up sequence.
- **Byte-write engine:** each byte is sent in three phases.
  - SETUP: 1 cycle; drive `lcd_rs` and `lcd_data`, `lcd_e`=0.
  - PULSE: `E_PULSE_CYC` cycles with `lcd_e`=1.
  - HOLD: `lcd_e`=0 for the wait count (`CLR_WAIT_CYC` after 0x01, otherwise `CMD_WAIT_CYC`).
  - `lcd_rs` and `lcd_data` stay stable through all three phases.
- **States:**
  - PWR_WAIT: count `INIT_WAIT_CYC`, then go to INIT.
  - INIT: send commands 0x38, 0x0C, 0x06, 0x01 in that order, then go to IDLE.
  - IDLE: `busy`=0. On `start`=1, latch `sel` and `result`, then go to CONV.
  - CONV: binary-to-BCD conversion, then go to CLEAR.
  - CLEAR: send 0x01, then go to CHARS.
  - CHARS: send the string as data (`lcd_rs`=1), pulse `done`, then return to IDLE.
- **String format:** three-letter mnemonic, `=`, then three decimal digits with leading zeros (000–255). 7 characters total.
- **Mnemonic map:**
  - 0000 ADD, 0001 SUB, 0010 MUL, 0011 INC, 0100 DEC, 1000 DIV, 1001 MOD.
  - Any other code displays `---`.
- **Latching:** `sel` and `result` are latched only on the accepted `start`. Later input changes do not affect the sequence in progress.
- **Start handling:**
  - `start` while `busy`=1 is dropped, not queued.
  - `start` on the same cycle that `done` pulses is dropped.
  - `start` on the first cycle of IDLE is accepted.
- **Reset mid-sequence:** abort immediately, drive reset values, and restart from PWR_WAIT.

## Timing
- Cost of one byte: B = 1 + `E_PULSE_CYC` + wait.
- `busy` rises the cycle after `start` is sampled in IDLE.
- CONV takes exactly 9 cycles: 1 load plus 8 shift/add-3 steps.
- First SETUP of the clear command occurs 10 cycles after `start` is sampled.
- The `done` pulse falls in the cycle after the final HOLD count expires. `busy` falls in the same cycle.
- Start-to-done latency = 10 + (1 + `E_PULSE_CYC` + `CLR_WAIT_CYC`) + N × (1 + `E_PULSE_CYC` + `CMD_WAIT_CYC`), where N is the character count.
- The power-up sequence finishes `INIT_WAIT_CYC` + 3 normal bytes + 1 clear byte after reset release. `busy` falls at that point.
- Wait counters are wide enough for `INIT_WAIT_CYC` and do not wrap.

## Configuration
- **`LCD_HEX_EN` defined:** after the decimal digits, append a space, `x`, and two uppercase hex digits of `result`, e.g. `MUL=225 xE1`. N = 11.
- **`LCD_HEX_EN` undefined:** N = 7, and no hex-formatting logic is built.

## Structure
- **Package `alu_lcd_pkg`:**
  - ALU select-code constants (shared with the ALU).
  - LCD command constants (0x38, 0x0C, 0x06, 0x01).
  - State enum.
  - Mnemonic lookup function returning three ASCII bytes.
  - Nibble-to-ASCII-hex function.
- **Sub-module `bin2bcd8`:**
  - Sequential double-dabble converter.
  - Ports: `clk`, `rst`, `load`, `bin[7:0]`, `bcd[11:0]`, `valid`.
  - 9-cycle latency from `load`.

## Test plan
All scenarios use `E_PULSE_CYC`=2, `CMD_WAIT_CYC`=4, `CLR_WAIT_CYC`=8, `INIT_WAIT_CYC`=16, with a bus monitor capturing a byte on each falling edge of `lcd_e`.
- **Reset and init:** release reset → monitor sees commands 38, 0C, 06, 01; `busy` falls at cycle 16+3×7+11; `lcd_rw` is always 0.
- **Multiply display:** `sel`=0010, `result`=225, `start` → clear, then data `M`,`U`,`L`,`=`,`2`,`2`,`5`; one `done` pulse at start+10+11+7×7 cycles.
- **Unknown code and zero:** `sel`=0111, `result`=0 → `---=000`; `sel`=1001, `result`=255 → `MOD=255`.
- **Start while busy:** second `start` with `result`=7 during CHARS → ignored; display still shows the first value; exactly one `done`.
- **Reset mid-sequence:** reset asserted during the third character → outputs return to reset values next cycle, the full init sequence repeats, and no `done` is produced.
- **Hex build (`LCD_HEX_EN` defined):** `sel`=0000, `result`=0x1F → `ADD=031 x1F`, 11 data bytes.

Source files
------------

// File: rtl/alu_lcd_pkg.sv
// Shared constants and helpers for the ALU result LCD writer.
// ALU select codes, HD44780 commands, FSM enums and ASCII formatting.
package alu_lcd_pkg;

  localparam logic [3:0] SEL_ADD = 4'b0000;
  localparam logic [3:0] SEL_SUB = 4'b0001;
  localparam logic [3:0] SEL_MUL = 4'b0010;
  localparam logic [3:0] SEL_INC = 4'b0011;
  localparam logic [3:0] SEL_DEC = 4'b0100;
  localparam logic [3:0] SEL_DIV = 4'b1000;
  localparam logic [3:0] SEL_MOD = 4'b1001;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_INIT,
    ST_IDLE,
    ST_CONV,
    ST_CLEAR,
    ST_CHARS
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP,
    PH_PULSE,
    PH_HOLD
  } phase_t;

  function automatic logic [23:0] mnemonic(input logic [3:0] code);
    case (code)
      SEL_ADD: return "ADD";
      SEL_SUB: return "SUB";
      SEL_MUL: return "MUL";
      SEL_INC: return "INC";
      SEL_DEC: return "DEC";
      SEL_DIV: return "DIV";
      SEL_MOD: return "MOD";
      default: return "---";
    endcase
  endfunction

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/alu_lcd_writer_bin2bcd8.sv
// Sequential double-dabble: 8-bit binary to three BCD digits.
// valid rises 9 cycles after load and holds until the next load.
module bin2bcd8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [7:0]  bin,
  output logic [11:0] bcd,
  output logic        valid
);

  logic [19:0] sh;
  logic [19:0] adj;
  logic [3:0]  steps;
  logic        run;

  // add-3 on every digit that would overflow past 9 after the shift
  always_comb begin
    adj = sh;
    if (adj[11:8] >= 4'd5)  adj[11:8]  = adj[11:8]  + 4'd3;
    if (adj[15:12] >= 4'd5) adj[15:12] = adj[15:12] + 4'd3;
    if (adj[19:16] >= 4'd5) adj[19:16] = adj[19:16] + 4'd3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh    <= '0;
      steps <= '0;
      run   <= 1'b0;
    end else if (load) begin
      sh    <= {12'd0, bin};
      steps <= 4'd8;
      run   <= 1'b1;
    end else if (steps != 4'd0) begin
      sh    <= {adj[18:0], 1'b0};
      steps <= steps - 4'd1;
    end
  end

  assign bcd   = sh[19:8];
  assign valid = run && (steps == 4'd0);

endmodule

// File: rtl/alu_lcd_writer.sv
// Displays one latched ALU result on an HD44780 LCD (8-bit, write-only), e.g. "MUL=225".
// Define LCD_HEX_EN to append " xHH" (uppercase hex of the result).
//
// state      | meaning
// PWR_WAIT   | power-up delay before the first command
// INIT       | send 38, 0C, 06, 01
// IDLE       | wait for start (dropped during the done cycle)
// CONV       | binary-to-BCD conversion
// CLEAR      | send clear command
// CHARS      | send the text as data bytes
module alu_lcd_writer
  import alu_lcd_pkg::*;
#(
  parameter int E_PULSE_CYC   = 25,
  parameter int CMD_WAIT_CYC  = 2500,
  parameter int CLR_WAIT_CYC  = 100000,
  parameter int INIT_WAIT_CYC = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] sel,
  input  logic [7:0] result,
  output logic       busy,
  output logic       done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  localparam int MAX_A    = (E_PULSE_CYC > CMD_WAIT_CYC) ? E_PULSE_CYC : CMD_WAIT_CYC;
  localparam int MAX_B    = (CLR_WAIT_CYC > INIT_WAIT_CYC) ? CLR_WAIT_CYC : INIT_WAIT_CYC;
  localparam int MAX_WAIT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

  localparam logic [CNT_W-1:0] E_LOAD    = CNT_W'(E_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LOAD  = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LOAD  = CNT_W'(CLR_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] INIT_LOAD = CNT_W'(INIT_WAIT_CYC - 1);

`ifdef LCD_HEX_EN
  localparam logic [3:0] LAST_CHAR = 4'd10;
`else
  localparam logic [3:0] LAST_CHAR = 4'd6;
`endif

  state_t           state, state_n;
  phase_t           phase, phase_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       idx, idx_n;
  logic [3:0]       sel_q;
  logic             done_q, done_n;
  logic             load;
  logic [11:0]      bcd;
  logic             bcd_valid;
  logic [23:0]      mn;
  logic [7:0]       char_byte, cur_byte;
  logic             cur_rs, sending, is_clr;
`ifdef LCD_HEX_EN
  logic [7:0]       res_q;
`endif

  bin2bcd8 u_bcd (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .bin   (result),
    .bcd   (bcd),
    .valid (bcd_valid)
  );

  always_comb begin
    mn        = mnemonic(sel_q);
    char_byte = 8'h00;
    case (idx)
      4'd0: char_byte = mn[23:16];
      4'd1: char_byte = mn[15:8];
      4'd2: char_byte = mn[7:0];
      4'd3: char_byte = "=";
      4'd4: char_byte = {4'h3, bcd[11:8]};
      4'd5: char_byte = {4'h3, bcd[7:4]};
      4'd6: char_byte = {4'h3, bcd[3:0]};
`ifdef LCD_HEX_EN
      4'd7:  char_byte = " ";
      4'd8:  char_byte = "x";
      4'd9:  char_byte = hex_ascii(res_q[7:4]);
      4'd10: char_byte = hex_ascii(res_q[3:0]);
`endif
      default: char_byte = 8'h00;
    endcase
  end

  always_comb begin
    cur_byte = 8'h00;
    cur_rs   = 1'b0;
    sending  = 1'b0;
    case (state)
      ST_INIT: begin
        sending = 1'b1;
        case (idx[1:0])
          2'd0:    cur_byte = LCD_FUNC_SET;
          2'd1:    cur_byte = LCD_DISP_ON;
          2'd2:    cur_byte = LCD_ENTRY;
          default: cur_byte = LCD_CLEAR;
        endcase
      end
      ST_CLEAR: begin
        sending  = 1'b1;
        cur_byte = LCD_CLEAR;
      end
      ST_CHARS: begin
        sending  = 1'b1;
        cur_rs   = 1'b1;
        cur_byte = char_byte;
      end
      default: ;
    endcase
  end

  assign is_clr = !cur_rs && (cur_byte == LCD_CLEAR);

  always_comb begin
    state_n = state;
    phase_n = phase;
    cnt_n   = cnt;
    idx_n   = idx;
    done_n  = 1'b0;
    load    = 1'b0;
    case (state)
      ST_PWR_WAIT: begin
        if (cnt == '0) begin
          state_n = ST_INIT;
          phase_n = PH_SETUP;
          idx_n   = 4'd0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ST_IDLE: begin
        if (start && !done_q) begin
          load    = 1'b1;
          state_n = ST_CONV;
        end
      end
      ST_CONV: begin
        if (bcd_valid) begin
          state_n = ST_CLEAR;
          phase_n = PH_SETUP;
        end
      end
      default: begin
        case (phase)
          PH_SETUP: begin
            phase_n = PH_PULSE;
            cnt_n   = E_LOAD;
          end
          PH_PULSE: begin
            if (cnt == '0) begin
              phase_n = PH_HOLD;
              cnt_n   = is_clr ? CLR_LOAD : CMD_LOAD;
            end else begin
              cnt_n = cnt - 1'b1;
            end
          end
          default: begin
            if (cnt == '0) begin
              phase_n = PH_SETUP;
              idx_n   = idx + 4'd1;
              if (state == ST_INIT && idx == 4'd3) begin
                state_n = ST_IDLE;
                idx_n   = 4'd0;
              end else if (state == ST_CLEAR) begin
                state_n = ST_CHARS;
                idx_n   = 4'd0;
              end else if (state == ST_CHARS && idx == LAST_CHAR) begin
                state_n = ST_IDLE;
                idx_n   = 4'd0;
                done_n  = 1'b1;
              end
            end else begin
              cnt_n = cnt - 1'b1;
            end
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_PWR_WAIT;
      phase  <= PH_SETUP;
      cnt    <= INIT_LOAD;
      idx    <= '0;
      done_q <= 1'b0;
      sel_q  <= '0;
`ifdef LCD_HEX_EN
      res_q  <= '0;
`endif
    end else begin
      state  <= state_n;
      phase  <= phase_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      done_q <= done_n;
      if (load) begin
        sel_q <= sel;
`ifdef LCD_HEX_EN
        res_q <= result;
`endif
      end
    end
  end

  assign busy     = (state != ST_IDLE);
  assign done     = done_q;
  assign lcd_rs   = cur_rs;
  assign lcd_rw   = 1'b0;
  assign lcd_e    = sending && (phase == PH_PULSE);
  assign lcd_data = cur_byte;

endmodule

// File: tb/tb_alu_lcd_writer.sv
// Directed bench for alu_lcd_writer with short timings; a bus monitor logs
// {rs,data} on each falling edge of lcd_e. Honours LCD_HEX_EN.
module tb_alu_lcd_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] sel = 4'd0;
  logic [7:0] result = 8'd0;
  logic       busy, done, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_data;

  int         cyc = 0;
  int         done_cnt = 0;
  logic       rw_bad = 1'b0;
  int         total = 0;
  int         bad = 0;
  logic [8:0] mon[$];

`ifdef LCD_HEX_EN
  localparam int NCH = 11;
  string s_mul = "MUL=225 xE1";
  string s_unk = "---=000 x00";
  string s_mod = "MOD=255 xFF";
  string s_sub = "SUB=100 x64";
  string s_add = "ADD=031 x1F";
`else
  localparam int NCH = 7;
  string s_mul = "MUL=225";
  string s_unk = "---=000";
  string s_mod = "MOD=255";
  string s_sub = "SUB=100";
  string s_add = "ADD=031";
`endif
  localparam int LAT      = 10 + 11 + NCH * 7;
  localparam int INIT_LAT = 16 + 3 * 7 + 11;

  alu_lcd_writer #(
    .E_PULSE_CYC   (2),
    .CMD_WAIT_CYC  (4),
    .CLR_WAIT_CYC  (8),
    .INIT_WAIT_CYC (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sel      (sel),
    .result   (result),
    .busy     (busy),
    .done     (done),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_e    (lcd_e),
    .lcd_data (lcd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge lcd_e) if (!rst) mon.push_back({lcd_rs, lcd_data});
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (lcd_rw !== 1'b0) rw_bad <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_rs"}, 32'(lcd_rs), 32'd0);
    check({tag, "_rw"}, 32'(lcd_rw), 32'd0);
    check({tag, "_e"}, 32'(lcd_e), 32'd0);
    check({tag, "_data"}, 32'(lcd_data), 32'h00);
  endtask

  task automatic check_init(input string tag);
    logic [8:0] exp_cmd [4];
    exp_cmd = '{9'h038, 9'h00C, 9'h006, 9'h001};
    check({tag, "_len"}, 32'(mon.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_cmd%0d", tag, i), (i < mon.size()) ? 32'(mon[i]) : 32'hFFFF,
            32'(exp_cmd[i]));
    mon.delete();
  endtask

  task automatic check_text(input string tag, input string s);
    check({tag, "_len"}, 32'(mon.size()), 32'(s.len() + 1));
    check({tag, "_clr"}, (mon.size() > 0) ? 32'(mon[0]) : 32'hFFFF, 32'h001);
    for (int i = 0; i < s.len(); i++)
      check($sformatf("%s_ch%0d", tag, i), (i + 1 < mon.size()) ? 32'(mon[i+1]) : 32'hFFFF,
            32'({1'b1, s[i]}));
    mon.delete();
  endtask

  task automatic wait_busy_low(input int maxc, output int at);
    at = -1000;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_done(input int maxc, output int at);
    at = -1000;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  // start is high during cycle t; inputs are scrambled afterwards to prove latching
  task automatic kick(input logic [3:0] s, input logic [7:0] r, output int t);
    sel    = s;
    result = r;
    start  = 1'b1;
    t      = cyc;
    @(posedge clk);
    #1;
    start  = 1'b0;
    sel    = ~s;
    result = ~r;
  endtask

  task automatic wait_mon(input int n, input logic need_e, input int maxc, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (mon.size() >= n && (!need_e || lcd_e === 1'b1)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int   t, s, r0;
    logic ok;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b0;
    r0  = cyc;
    wait_busy_low(200, t);
    check("init_busy_fall", 32'(t - r0), 32'(INIT_LAT));
    check_init("init");
    check("init_no_done", 32'(done_cnt), 32'd0);

    // accepted on the very first IDLE cycle
    kick(4'b0010, 8'd225, s);
    check("busy_rise", 32'(busy), 32'd1);
    wait_done(400, t);
    check("mul_latency", 32'(t - s), 32'(LAT));
    check("busy_low_with_done", 32'(busy), 32'd0);
    sel    = 4'd0;
    result = 8'd5;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_on_done_dropped", 32'(busy), 32'd0);
    check_text("mul", s_mul);
    check("mul_done_cnt", 32'(done_cnt), 32'd1);

    @(negedge clk);
    kick(4'b0111, 8'd0, s);
    wait_done(400, t);
    check("unk_latency", 32'(t - s), 32'(LAT));
    check_text("unk", s_unk);

    @(negedge clk);
    kick(4'b1001, 8'd255, s);
    wait_done(400, t);
    check("mod_latency", 32'(t - s), 32'(LAT));
    check_text("mod", s_mod);

    @(negedge clk);
    kick(4'b0001, 8'd100, s);
    wait_mon(2, 1'b0, 200, ok);
    check("sub_reach_chars", 32'(ok), 32'd1);
    sel    = 4'd0;
    result = 8'd7;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(400, t);
    check("sub_latency", 32'(t - s), 32'(LAT));
    repeat (20) @(negedge clk);
    check("busy_start_not_queued", 32'(busy), 32'd0);
    check("sub_done_cnt", 32'(done_cnt), 32'd4);
    check_text("sub", s_sub);

    kick(4'b0000, 8'h1F, s);
    wait_done(400, t);
    check("add_latency", 32'(t - s), 32'(LAT));
    check_text("add", s_add);

    @(negedge clk);
    kick(4'b0011, 8'd42, s);
    wait_mon(3, 1'b1, 200, ok);
    check("mid_reach_third_char", 32'(ok), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("mid_rst");
    mon.delete();
    rst = 1'b0;
    r0  = cyc;
    wait_busy_low(200, t);
    check("reinit_busy_fall", 32'(t - r0), 32'(INIT_LAT));
    check_init("reinit");
    check("mid_no_done", 32'(done_cnt), 32'd5);
    check("lcd_rw_always_0", 32'(rw_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
